// File: rtl/maze_video_pkg.sv
// Shared types and default geometry for the maze video source and path-finder.
package maze_video_pkg;

    typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} video_state_t;

    localparam int MAZE_H_ACTIVE = 702;
    localparam int MAZE_V_ACTIVE = 288;
    localparam int SCAN_ROW      = 16;
    localparam int END_ROW       = MAZE_V_ACTIVE - 1;
    localparam int END_COL       = MAZE_H_ACTIVE - 1;
    localparam int BIN_THRESHOLD = 150;

    function automatic int unsigned pixel_index(input int unsigned row, input int unsigned col);
        return row * MAZE_H_ACTIVE + col;
    endfunction

endpackage

// File: rtl/video_blank_timer.sv
// Loadable down-counter; done is high for the single cycle the count reaches zero.
module video_blank_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;
    logic         busy;

    assign done = busy && (count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            busy  <= 1'b0;
        end else if (load) begin
            count <= load_val;
            busy  <= 1'b1;
        end else if (done) begin
            busy  <= 1'b0;
        end else if (busy) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/maze_frame_source.sv
// Raster-order frame reader producing a blanked, framed 8-bit video stream.
module maze_frame_source
    import maze_video_pkg::*;
#(
    parameter int H_ACTIVE = MAZE_H_ACTIVE,
    parameter int V_ACTIVE = MAZE_V_ACTIVE,
    parameter int H_BLANK  = 32,
    parameter int V_BLANK  = 64,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              video_frame_valid,
    output logic              video_line_valid,
    output logic              video_data_valid,
    output logic [7:0]        video_data_out,
    output logic [ADDR_W-1:0] video_address,
    input  logic              video_data_ready,
    output logic              ready_err,
    output logic [9:0]        frame_count
);

    localparam int HW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int VW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int TW = $clog2(((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK) + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE - 1);
    localparam logic [TW-1:0] H_LOAD = TW'(H_BLANK - 1);
    localparam logic [TW-1:0] V_LOAD = TW'(V_BLANK - 1);

    video_state_t  state;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;
    logic          in_frame;

    // The timer is loaded on the same edge the FSM enters a blanking state.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = V_LOAD;
        case (state)
            IDLE:    tmr_load = enable;
            ACTIVE:  if (h == H_LAST) begin
                         tmr_load = 1'b1;
                         tmr_val  = H_LOAD;
                     end
            HBLANK:  tmr_load = tmr_done && (v == V_LAST) && enable;
            default: tmr_load = 1'b0;
        endcase
    end

    video_blank_timer #(.W(TW)) u_blank_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            h         <= '0;
            v         <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
        end else begin
            case (state)
                IDLE: if (enable) state <= VBLANK;
                VBLANK: if (tmr_done) begin
                    state     <= ACTIVE;
                    h         <= '0;
                    v         <= '0;
                    mem_rd_en <= 1'b1;
                    mem_addr  <= '0;
                end
                ACTIVE: if (h == H_LAST) begin
                    state     <= HBLANK;
                    mem_rd_en <= 1'b0;
                end else begin
                    h         <= h + HW'(1);
                    mem_addr  <= mem_addr + ADDR_W'(1);
                end
                HBLANK: if (tmr_done) begin
                    if (v < V_LAST) begin
                        state     <= ACTIVE;
                        v         <= v + VW'(1);
                        h         <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                    end else begin
                        state <= enable ? VBLANK : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_frame       = (state == ACTIVE) || (state == HBLANK);
    assign video_data_out = mem_rdata;

    // Controls are delayed one stage so they line up with the synchronous read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            video_frame_valid <= 1'b0;
            video_line_valid  <= 1'b0;
            video_data_valid  <= 1'b0;
            video_address     <= '0;
            ready_err         <= 1'b0;
            frame_count       <= '0;
        end else begin
            video_frame_valid <= in_frame;
            video_line_valid  <= mem_rd_en;
            video_data_valid  <= mem_rd_en;
            video_address     <= mem_addr;
            if (video_frame_valid && !in_frame) frame_count <= frame_count + 10'd1;
            if (video_data_valid && !video_data_ready) ready_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_maze_frame_source.sv
// Directed bench: small-geometry source plus a tall-frame instance using the default line count.
module tb_maze_frame_source;

    logic        clk = 1'b0;
    logic        reset, enable, video_data_ready;
    logic        mem_rd_en;
    logic [19:0] mem_addr;
    logic [7:0]  mem_rdata = '0;
    logic        video_frame_valid, video_line_valid, video_data_valid;
    logic [7:0]  video_data_out;
    logic [19:0] video_address;
    logic        ready_err;
    logic [9:0]  frame_count;

    logic        reset_b, enable_b;
    logic        ready_b = 1'b1;
    logic        mem_rd_en_b;
    logic [19:0] mem_addr_b;
    logic [7:0]  mem_rdata_b = '0;
    logic        fv_b, lv_b, dv_b, rerr_b;
    logic [7:0]  do_b;
    logic [19:0] va_b;
    logic [9:0]  fc_b;

    int unsigned errors = 0, checks = 0;
    int unsigned exp_addr = 0, pix_cnt = 0, line_falls = 0;
    int unsigned fv_low = 0, last_gap = 0, gap_run = 0;
    logic        fv_prev = 1'b0, lv_prev = 1'b0;
    int unsigned pix_b = 0, line_falls_b = 0, last_addr_b = 0;
    logic        fvb_prev = 1'b0, lvb_prev = 1'b0;

    always #5 clk = ~clk;

    maze_frame_source #(.H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .V_BLANK(5), .ADDR_W(20)) u_dut (
        .clk(clk), .reset(reset), .enable(enable),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .video_frame_valid(video_frame_valid), .video_line_valid(video_line_valid),
        .video_data_valid(video_data_valid), .video_data_out(video_data_out),
        .video_address(video_address), .video_data_ready(video_data_ready),
        .ready_err(ready_err), .frame_count(frame_count)
    );

    maze_frame_source #(.H_ACTIVE(16), .H_BLANK(1), .V_BLANK(2)) u_dut_tall (
        .clk(clk), .reset(reset_b), .enable(enable_b),
        .mem_rd_en(mem_rd_en_b), .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b),
        .video_frame_valid(fv_b), .video_line_valid(lv_b),
        .video_data_valid(dv_b), .video_data_out(do_b),
        .video_address(va_b), .video_data_ready(ready_b),
        .ready_err(rerr_b), .frame_count(fc_b)
    );

    // Frame memories preloaded with data = address (low byte).
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr[7:0];
    always @(posedge clk) if (mem_rd_en_b) mem_rdata_b <= mem_addr_b[7:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fv(input logic target, input int unsigned limit, input string tag);
        int unsigned n = 0;
        while (video_frame_valid !== target && n < limit) begin
            tick();
            n++;
        end
        check(tag, video_frame_valid, target);
    endtask

    task automatic wait_pixel(input int unsigned k, input int unsigned limit, input string tag);
        int unsigned n = 0;
        while (!(video_data_valid === 1'b1 && video_address == k) && n < limit) begin
            tick();
            n++;
        end
        check(tag, video_address, k);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        if (!video_frame_valid) begin
            exp_addr = 0;
        end else if (!fv_prev) begin
            last_gap   = fv_low;
            pix_cnt    = 0;
            line_falls = 0;
            gap_run    = 0;
        end
        if (video_data_valid) begin
            check("pix_addr", video_address, exp_addr);
            check("pix_data", video_data_out, exp_addr & 32'hff);
            check("pix_in_frame", video_frame_valid, 1);
            exp_addr++;
            pix_cnt++;
        end
        if (video_line_valid || video_data_valid)
            check("line_eq_data", video_line_valid, video_data_valid);
        if (lv_prev && !video_line_valid) line_falls++;
        if (video_frame_valid) begin
            if (video_line_valid && !lv_prev && gap_run != 0) check("line_gap", gap_run, 2);
            gap_run = video_line_valid ? 0 : gap_run + 1;
        end
        fv_low  = video_frame_valid ? 0 : fv_low + 1;
        fv_prev = video_frame_valid;
        lv_prev = video_line_valid;
    end

    always @(negedge clk) begin
        if (fv_b && !fvb_prev) begin
            pix_b        = 0;
            line_falls_b = 0;
        end
        if (dv_b) begin
            check("b_pix_addr", va_b, pix_b);
            last_addr_b = va_b;
            pix_b++;
        end
        if (lvb_prev && !lv_b) line_falls_b++;
        fvb_prev = fv_b;
        lvb_prev = lv_b;
    end

    initial begin
        int unsigned n;
        int unsigned seen;
        reset = 1'b1; enable = 1'b0; video_data_ready = 1'b1;
        reset_b = 1'b1; enable_b = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_fv", video_frame_valid, 0);
        check("rst_lv", video_line_valid, 0);
        check("rst_dv", video_data_valid, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_vaddr", video_address, 0);
        check("rst_count", frame_count, 0);
        check("rst_rerr", ready_err, 0);

        // First frame latency and shape
        enable = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!video_frame_valid && n < 50);
        check("fv_latency", n, 7);
        check("first_dv", video_data_valid, 1);
        check("first_addr", video_address, 0);
        wait_fv(1'b0, 200, "f1_end");
        check("f1_pixels", pix_cnt, 12);
        check("f1_lines", line_falls, 3);
        check("f1_count", frame_count, 1);

        // Continuous frames
        wait_fv(1'b1, 50, "f2_start");
        check("vblank_gap", last_gap, 5);
        wait_fv(1'b0, 200, "f2_end");
        check("f2_pixels", pix_cnt, 12);
        check("f2_count", frame_count, 2);
        wait_fv(1'b1, 50, "f3_start");
        check("vblank_gap3", last_gap, 5);
        wait_fv(1'b0, 200, "f3_end");
        check("f3_count", frame_count, 3);

        // Enable dropped during line 1
        do_reset();
        check("rst2_count", frame_count, 0);
        enable = 1'b1;
        wait_pixel(5, 200, "drop_pix");
        enable = 1'b0;
        wait_fv(1'b0, 200, "drop_end");
        check("drop_pixels", pix_cnt, 12);
        check("drop_count", frame_count, 1);
        seen = 0;
        repeat (30) begin
            tick();
            seen = seen | 32'(video_frame_valid | video_data_valid | mem_rd_en);
        end
        check("idle_quiet", seen, 0);
        check("idle_pixels", pix_cnt, 12);
        check("held_addr", mem_addr, 11);

        // Reset mid-frame on pixel 6
        do_reset();
        enable = 1'b1;
        wait_pixel(6, 200, "abort_pix");
        reset = 1'b1;
        tick();
        check("abort_fv", video_frame_valid, 0);
        check("abort_lv", video_line_valid, 0);
        check("abort_dv", video_data_valid, 0);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_count", frame_count, 0);
        reset = 1'b0;
        wait_pixel(0, 60, "restart_addr");

        // One cycle of ready low
        check("rerr_pre", ready_err, 0);
        video_data_ready = 1'b0;
        tick();
        video_data_ready = 1'b1;
        enable = 1'b0;
        check("rerr_set", ready_err, 1);
        wait_fv(1'b0, 200, "restart_end");
        check("restart_pixels", pix_cnt, 12);
        check("restart_count", frame_count, 1);
        check("rerr_sticky", ready_err, 1);
        do_reset();
        check("rerr_clear", ready_err, 0);

        // Tall frame with the default line count
        reset_b = 1'b0;
        enable_b = 1'b1;
        n = 0;
        while (!fv_b && n < 20) begin
            tick();
            n++;
        end
        enable_b = 1'b0;
        check("b_start", fv_b, 1);
        n = 0;
        while (fv_b && n < 6000) begin
            tick();
            n++;
        end
        check("b_end", fv_b, 0);
        check("b_lines", line_falls_b, 288);
        check("b_pixels", pix_b, 4608);
        check("b_last_addr", last_addr_b, 4607);
        check("b_count", fc_b, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
